axis_mask_uart_tx: RTL and testbench

AXIS_MASK_UART_TX -- requirements
Module: axis_mask_uart_tx

---
 rtl/axis_ask_pkg.sv | 25 ++
 rtl/axis_sync_fifo.sv | 65 ++++++
 rtl/axis_mask_uart_tx.sv | 180 ++++++++++++++++++
 tb/tb_axis_mask_uart_tx.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_ask_pkg.sv
// Shared types and constants for the AXIS-to-ASK UART transmitter family.
// Parity mode strings are 32-bit so overrides compare without width games.
package axis_ask_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam logic [31:0] PAR_NONE = "none";
    localparam logic [31:0] PAR_EVEN = "even";
    localparam logic [31:0] PAR_ODD  = {8'h00, "odd"};

    function automatic int frame_syms(
        input int          sym_bits,
        input logic [31:0] parity,
        input int          stop_syms
    );
        return 1 + 8 / sym_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_syms;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with registered occupancy count.
// Push and pop together on full or empty leave the count unchanged.
module axis_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("axis_sync_fifo: DEPTH must be a power of 2, >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && (!empty || push);

    // Empty bypass: a same-cycle push/pop hands the incoming word straight out
    assign rd_data = empty ? wr_data : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_mask_uart_tx.sv
// AXI-Stream byte input, UART-style framing, multi-level ASK symbol output.
// ask_tx is a registered image of the current FSM symbol, one cycle behind.
module axis_mask_uart_tx
    import axis_ask_pkg::*;
#(
    parameter int          SYM_BITS   = 2,
    parameter int          CLKDIV     = 100,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] PARITY     = PAR_NONE,
    parameter int          STOP_SYMS  = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  i_tdata,
    input  logic                        i_tvalid,
    output logic                        i_tready,
    input  logic                        i_en,
    output logic [SYM_BITS-1:0]         ask_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int DATA_SYMS = 8 / SYM_BITS;
    localparam int DIV_W     = $clog2(CLKDIV);

    localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(CLKDIV - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_SYMS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_SYMS - 1);
    localparam bit               HAS_PAR   = (PARITY != PAR_NONE);
    localparam logic             ODD_PAR   = (PARITY == PAR_ODD);

    if (SYM_BITS != 1 && SYM_BITS != 2 && SYM_BITS != 4) begin : g_bad_sym
        $error("axis_mask_uart_tx: SYM_BITS must be 1, 2 or 4");
    end
    if (CLKDIV < 2) begin : g_bad_div
        $error("axis_mask_uart_tx: CLKDIV must be >= 2");
    end
    if (STOP_SYMS != 1 && STOP_SYMS != 2) begin : g_bad_stop
        $error("axis_mask_uart_tx: STOP_SYMS must be 1 or 2");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_par
        $error("axis_mask_uart_tx: PARITY must be none, even or odd");
    end

    tx_state_t            state, state_n;
    logic [DIV_W-1:0]     div, div_n;
    logic [2:0]           idx, idx_n;
    logic [7:0]           shreg, shreg_n;
    logic                 par_bit, par_n;
    logic [SYM_BITS-1:0]  ask_n;
    logic                 rdy_en;
    logic                 push;
    logic                 pop;
    logic [7:0]           fifo_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 sym_end;
    logic                 can_start;

    // Ready is held off until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    assign i_tready  = rdy_en && !fifo_full;
    assign push      = i_tvalid && i_tready;
    assign sym_end   = (div == '0);
    assign can_start = !fifo_empty && i_en;
    assign busy      = (state != ST_IDLE);

    axis_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (i_tdata),
        .pop     (pop),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            div     <= '0;
            idx     <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            ask_tx  <= '1;
        end else begin
            state   <= state_n;
            div     <= div_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            par_bit <= par_n;
            ask_tx  <= ask_n;
        end
    end

    always_comb begin
        state_n = state;
        div_n   = div;
        idx_n   = idx;
        shreg_n = shreg;
        par_n   = par_bit;
        pop     = 1'b0;
        if (state != ST_IDLE && !sym_end) begin
            div_n = div - 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (can_start) begin
                        state_n = ST_START;
                        div_n   = DIV_MAX;
                        pop     = 1'b1;
                        shreg_n = fifo_data;
                        par_n   = (^fifo_data) ^ ODD_PAR;
                    end
                end
                ST_START: begin
                    state_n = ST_DATA;
                    idx_n   = '0;
                    div_n   = DIV_MAX;
                end
                ST_DATA: begin
                    div_n   = DIV_MAX;
                    shreg_n = shreg >> SYM_BITS;
                    if (idx == DATA_LAST) begin
                        idx_n   = '0;
                        state_n = HAS_PAR ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end
                ST_PARITY: begin
                    state_n = ST_STOP;
                    idx_n   = '0;
                    div_n   = DIV_MAX;
                end
                ST_STOP: begin
                    if (idx != STOP_LAST) begin
                        idx_n = idx + 3'd1;
                        div_n = DIV_MAX;
                    end else if (can_start) begin
                        // Back-to-back frame: reload without passing IDLE
                        state_n = ST_START;
                        div_n   = DIV_MAX;
                        pop     = 1'b1;
                        shreg_n = fifo_data;
                        par_n   = (^fifo_data) ^ ODD_PAR;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ask_n = '1;
        unique case (state)
            ST_START:  ask_n = '0;
            ST_DATA:   ask_n = shreg[SYM_BITS-1:0];
            ST_PARITY: ask_n = {SYM_BITS{par_bit}};
            default:   ask_n = '1;
        endcase
    end

endmodule

// File: tb/tb_axis_mask_uart_tx.sv
// Bench for axis_mask_uart_tx: five configurations, random bytes,
// expected symbol streams built from byte arithmetic.
module tb_axis_mask_uart_tx;
    import axis_ask_pkg::*;

    localparam int N = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] tdata  [N];
    logic       tvalid [N];
    logic       en     [N];

    logic       rdy0, rdy1, rdy2, rdy3, rdy4;
    logic       busy0, busy1, busy2, busy3, busy4;
    logic [1:0] ask0, ask1, ask2;
    logic [0:0] ask3;
    logic [3:0] ask4;
    logic [4:0] cnt0, cnt1, cnt2, cnt4;
    logic [2:0] cnt3;

    int tests = 0;
    int fails = 0;
    int max_cnt = 0;
    int exp_syms[$];

    axis_mask_uart_tx #(.SYM_BITS(2), .CLKDIV(4), .FIFO_DEPTH(16),
        .PARITY(PAR_NONE), .STOP_SYMS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .i_tdata(tdata[0]), .i_tvalid(tvalid[0]),
        .i_tready(rdy0), .i_en(en[0]), .ask_tx(ask0), .busy(busy0),
        .fifo_count(cnt0));

    axis_mask_uart_tx #(.SYM_BITS(2), .CLKDIV(4), .FIFO_DEPTH(16),
        .PARITY(PAR_EVEN), .STOP_SYMS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .i_tdata(tdata[1]), .i_tvalid(tvalid[1]),
        .i_tready(rdy1), .i_en(en[1]), .ask_tx(ask1), .busy(busy1),
        .fifo_count(cnt1));

    axis_mask_uart_tx #(.SYM_BITS(2), .CLKDIV(4), .FIFO_DEPTH(16),
        .PARITY(PAR_ODD), .STOP_SYMS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .i_tdata(tdata[2]), .i_tvalid(tvalid[2]),
        .i_tready(rdy2), .i_en(en[2]), .ask_tx(ask2), .busy(busy2),
        .fifo_count(cnt2));

    axis_mask_uart_tx #(.SYM_BITS(1), .CLKDIV(2), .FIFO_DEPTH(4),
        .PARITY(PAR_NONE), .STOP_SYMS(1)) u3 (
        .clk(clk), .rst_n(rst_n), .i_tdata(tdata[3]), .i_tvalid(tvalid[3]),
        .i_tready(rdy3), .i_en(en[3]), .ask_tx(ask3), .busy(busy3),
        .fifo_count(cnt3));

    axis_mask_uart_tx #(.SYM_BITS(4), .CLKDIV(2), .FIFO_DEPTH(16),
        .PARITY(PAR_NONE), .STOP_SYMS(2)) u4 (
        .clk(clk), .rst_n(rst_n), .i_tdata(tdata[4]), .i_tvalid(tvalid[4]),
        .i_tready(rdy4), .i_en(en[4]), .ask_tx(ask4), .busy(busy4),
        .fifo_count(cnt4));

    function automatic int sb_of(input int i);
        case (i)
            3:       return 1;
            4:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int cdiv_of(input int i);
        return (i >= 3) ? 2 : 4;
    endfunction

    // 0 = none, 1 = even, 2 = odd
    function automatic int par_of(input int i);
        return (i == 1) ? 1 : (i == 2) ? 2 : 0;
    endfunction

    function automatic int stops_of(input int i);
        return (i == 4) ? 2 : 1;
    endfunction

    function automatic int depth_of(input int i);
        return (i == 3) ? 4 : 16;
    endfunction

    function automatic logic [3:0] ask_of(input int i);
        case (i)
            0:       return {2'b00, ask0};
            1:       return {2'b00, ask1};
            2:       return {2'b00, ask2};
            3:       return {3'b000, ask3};
            default: return ask4;
        endcase
    endfunction

    function automatic logic busy_of(input int i);
        case (i)
            0:       return busy0;
            1:       return busy1;
            2:       return busy2;
            3:       return busy3;
            default: return busy4;
        endcase
    endfunction

    function automatic logic rdy_of(input int i);
        case (i)
            0:       return rdy0;
            1:       return rdy1;
            2:       return rdy2;
            3:       return rdy3;
            default: return rdy4;
        endcase
    endfunction

    function automatic logic [4:0] cnt_of(input int i);
        case (i)
            0:       return cnt0;
            1:       return cnt1;
            2:       return cnt2;
            3:       return {2'b00, cnt3};
            default: return cnt4;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Symbol list of one frame, derived from the byte value alone
    task automatic add_frame(input int i, input int b);
        int sb   = sb_of(i);
        int mask = (1 << sb) - 1;
        int ones = 0;
        int pbit;
        exp_syms.push_back(0);
        for (int k = 0; k < 8 / sb; k++) begin
            exp_syms.push_back((b >> (k * sb)) & mask);
        end
        for (int k = 0; k < 8; k++) begin
            ones += (b >> k) & 1;
        end
        if (par_of(i) != 0) begin
            pbit = ones % 2;
            if (par_of(i) == 2) pbit = 1 - pbit;
            exp_syms.push_back(pbit != 0 ? mask : 0);
        end
        for (int k = 0; k < stops_of(i); k++) begin
            exp_syms.push_back(mask);
        end
    endtask

    // Called #1 after an edge; returns #1 after the edge that accepted b
    task automatic push_byte(input int i, input int b);
        int n = 0;
        tdata[i]  = 8'(b);
        tvalid[i] = 1'b1;
        forever begin
            if (int'(cnt_of(i)) > max_cnt) max_cnt = int'(cnt_of(i));
            chk($sformatf("rdy_vs_cnt%0d", i), {7'd0, rdy_of(i)},
                {7'd0, (int'(cnt_of(i)) < depth_of(i))});
            if (rdy_of(i) === 1'b1) break;
            if (n == 5000) begin
                tests++;
                fails++;
                $error("FAIL push_timeout%0d: observed no ready expected ready", i);
                break;
            end
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        tvalid[i] = 1'b0;
    endtask

    // Reference edge E0 is the edge just passed; START is visible after E2
    task automatic check_stream(input int i);
        int         c     = cdiv_of(i);
        int         total = exp_syms.size() * c;
        logic [3:0] ones  = 4'((1 << sb_of(i)) - 1);
        logic [3:0] e;
        for (int k = 1; k <= total + 3; k++) begin
            @(posedge clk);
            #1;
            if (k >= 2 && k <= total + 1) e = 4'(exp_syms[(k - 2) / c]);
            else e = ones;
            chk($sformatf("ask%0d@%0d", i, k), {4'd0, ask_of(i)}, {4'd0, e});
            chk($sformatf("busy%0d@%0d", i, k), {7'd0, busy_of(i)},
                {7'd0, (k <= total)});
        end
    endtask

    task automatic run_frames(input int i, input int bytes[$]);
        exp_syms.delete();
        foreach (bytes[k]) add_frame(i, bytes[k]);
        push_byte(i, bytes[0]);
        fork
            begin
                for (int k = 1; k < bytes.size(); k++) push_byte(i, bytes[k]);
            end
            check_stream(i);
        join
        chk($sformatf("cnt_end%0d", i), {3'd0, cnt_of(i)}, 8'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int q[$];
        int b0, b1;
        for (int i = 0; i < N; i++) begin
            tdata[i]  = 8'h00;
            tvalid[i] = 1'b0;
            en[i]     = 1'b0;
        end
        #23;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_ask%0d", i), {4'd0, ask_of(i)},
                8'((1 << sb_of(i)) - 1));
            chk($sformatf("rst_busy%0d", i), {7'd0, busy_of(i)}, 8'd0);
            chk($sformatf("rst_cnt%0d", i), {3'd0, cnt_of(i)}, 8'd0);
            chk($sformatf("rst_rdy%0d", i), {7'd0, rdy_of(i)}, 8'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rdy_before_edge", {7'd0, rdy0}, 8'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rdy_after_rel%0d", i), {7'd0, rdy_of(i)}, 8'd1);
            en[i] = 1'b1;
        end

        q = '{'hB4};
        run_frames(0, q);
        q = '{$urandom_range(0, 255), $urandom_range(0, 255)};
        run_frames(0, q);

        q = '{'hB4, $urandom_range(0, 255)};
        run_frames(1, q);
        q = '{'hB4, $urandom_range(0, 255)};
        run_frames(2, q);

        max_cnt = 0;
        q.delete();
        for (int k = 0; k < 6; k++) q.push_back($urandom_range(0, 255));
        run_frames(3, q);
        chk("max_cnt3", 8'(max_cnt), 8'd4);

        b0 = $urandom_range(0, 255);
        b1 = $urandom_range(0, 255);
        exp_syms.delete();
        add_frame(4, b0);
        push_byte(4, b0);
        fork
            begin
                push_byte(4, b1);
                repeat (3) @(posedge clk);
                #1;
                en[4] = 1'b0;
            end
            check_stream(4);
        join
        chk("en_hold_cnt", {3'd0, cnt4}, 8'd1);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("en_hold_ask", {4'd0, ask4}, 8'h0F);
            chk("en_hold_busy", {7'd0, busy4}, 8'd0);
        end
        exp_syms.delete();
        add_frame(4, b1);
        en[4] = 1'b1;
        check_stream(4);
        chk("en_resume_cnt", {3'd0, cnt4}, 8'd0);

        for (int k = 0; k < 3; k++) push_byte(0, $urandom_range(0, 255));
        repeat (4) @(posedge clk);
        #1;
        chk("mid_frame_busy", {7'd0, busy0}, 8'd1);
        rst_n = 1'b0;
        #2;
        for (int r = 0; r < 2; r++) begin
            chk("arst_ask", {6'd0, ask0}, 8'h03);
            chk("arst_busy", {7'd0, busy0}, 8'd0);
            chk("arst_cnt", {3'd0, cnt0}, 8'd0);
            chk("arst_rdy", {7'd0, rdy0}, 8'd0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            chk("post_rst_ask", {6'd0, ask0}, 8'h03);
            chk("post_rst_busy", {7'd0, busy0}, 8'd0);
        end
        chk("post_rst_cnt", {3'd0, cnt0}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
